seq_mul_add: RTL and testbench
==============================

Name: seq_mul_add

Overview:
- Parametrised, clocked successor to the combinational sum/product procedures block.
- Accepts an operand pair (a, b) on a valid/ready handshake and returns a registered WIDTH+1-bit sum plus a 2*WIDTH-bit product.
- The product is computed by an iterative shift-add multiplier, one multiplier bit per cycle.
- Optional per-transaction signed mode. Sits as a reusable arithmetic leaf under the adders/ tree.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- SIGNED_EN, 0, 1 enables the signed_mode input; 0 ties it internally to unsigned.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  operand A (multiplicand / addend).
- in_b  in  WIDTH  operand B (multiplier / addend).
- signed_mode  in  1  1 treats operands as two's complement; ignored when SIGNED_EN=0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH+1  a+b; zero-extended (unsigned) or sign-extended (signed).
- out_product  out  2*WIDTH  a*b.
- busy  out  1  high in MUL state.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_product=0, counter=0.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b, latch the effective mode (signed_mode & SIGNED_EN), compute and register out_sum, clear the accumulator, set counter=0, go to MUL.
- Signed operand preparation: multiplicand and multiplier are stored as magnitudes, and the result sign = sign(a) XOR sign(b).
- MUL:
  - in_ready=0, busy=1.
  - Each edge: if multiplier bit[counter]=1, add (multiplicand << counter) into the 2*WIDTH accumulator; counter increments.
  - At the edge where counter == WIDTH-1: load out_product (two's-complement negated if the result sign is 1), go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum and out_product stay stable while out_valid=1 and out_ready=0 (backpressure; hold indefinitely).
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
- Latency:
  - Accepting edge = edge 0. out_valid is high after edge WIDTH, so the first cycle it can be sampled is the WIDTH+1th after acceptance.
  - Fixed latency; no early termination for zero operands.
- Throughput: one transaction per WIDTH+2 cycles minimum. There is no back-to-back accept in DONE; a new accept is possible only in the cycle after the result handshake.
- Width rules:
  - out_sum never overflows (WIDTH+1 bits).
  - The product fits exactly in 2*WIDTH bits in both modes. The signed case -2^(W-1) * -2^(W-1) = 2^(2W-2) is representable.
  - The most-negative operand magnitude, 2^(W-1), must be handled as an unsigned WIDTH-bit value.
- Input hygiene:
  - in_a, in_b and signed_mode are sampled only on the accepting edge.
  - Changes during MUL or DONE do not affect the result.
  - in_valid outside IDLE is ignored, with no queueing.
- Reset mid-operation: rst in MUL or DONE aborts the transaction, returns to reset values on that edge, and discards the result. rst has priority over every handshake on the same edge.
- Outputs out_sum and out_product retain their last values after the handshake until the next result loads (out_sum reloads at accept).
- No combinational path from in_valid or out_ready to any output except via registered state. in_ready and out_valid are decoded from the state register only.

Test Plan:
- WIDTH=8 unsigned, a=10, b=99 -> out_valid after edge 8, out_sum=109, out_product=990; busy high for exactly 8 cycles.
- WIDTH=8 unsigned, a=255, b=255 -> out_sum=510 (9'h1FE), out_product=65025 (16'hFE01). Also a=0, b=200 -> sum=200, product=0, same fixed latency.
- WIDTH=8, SIGNED_EN=1, signed_mode=1:
  - a=-3 (8'hFD), b=5 -> out_sum=9'h002, out_product=16'hFFF1 (-15).
  - a=-128, b=-128 -> out_product=16'h4000, out_sum=9'h100 (-256).
- Backpressure: hold out_ready=0 for 20 cycles in DONE with in_valid=1 and changing inputs -> outputs stable, in_ready=0, no new accept. Raise out_ready -> IDLE next edge; the next transaction (a=33, b=132) yields sum=165, product=4356.
- Reset mid-MUL: accept a=10, b=99, assert rst for one edge at counter=4 -> all outputs return to reset values, out_valid never rises. The following transaction a=4, b=5 gives product=20.
- SIGNED_EN=0 with signed_mode=1, a=8'hFD, b=5 -> unsigned result: sum=258, product=1265.

Source files
------------

// File: rtl/seq_mul_add.sv
// Operand-pair arithmetic leaf: registered a+b at accept, a*b via iterative shift-add
// (one multiplier bit per cycle), optional per-transaction two's-complement mode.
module seq_mul_add #(
  parameter  int WIDTH     = 8,
  parameter  int SIGNED_EN = 0,
  localparam int CNT_W     = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       out_sum,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;

  logic                 eff_mode;
  logic [WIDTH-1:0]     a_mag, b_mag, mpl_sh;
  logic [WIDTH:0]       sum_next;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 last;

  assign eff_mode = (SIGNED_EN != 0) && signed_mode;

  // Magnitudes stay WIDTH-bit unsigned so -2^(W-1) maps to 2^(W-1) without overflow.
  assign a_mag = (eff_mode && in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
  assign b_mag = (eff_mode && in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;

  assign sum_next = eff_mode ? ({in_a[WIDTH-1], in_a} + {in_b[WIDTH-1], in_b})
                             : ({1'b0, in_a} + {1'b0, in_b});

  assign mpl_sh   = mplier >> cnt;
  assign acc_next = acc + (mpl_sh[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0);
  assign last     = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      out_sum     <= '0;
      out_product <= '0;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      neg         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand    <= a_mag;
          mplier   <= b_mag;
          neg      <= eff_mode & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          out_sum  <= sum_next;
          acc      <= '0;
          cnt      <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= MUL;
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            out_product <= neg ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
            busy        <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_add.sv
// Drives an unsigned-only instance and a signed-capable instance in lockstep from
// one stimulus stream; expectations come from a vector table and an integer model.
module tb_seq_mul_add;
  localparam int W = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, signed_mode = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
  logic [W:0] out_sum0, out_sum1;
  logic [2*W-1:0] out_product0, out_product1;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_mul_add #(.WIDTH(W), .SIGNED_EN(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
    .signed_mode(signed_mode), .out_valid(out_valid0), .out_ready(out_ready),
    .out_sum(out_sum0), .out_product(out_product0), .busy(busy0));

  seq_mul_add #(.WIDTH(W), .SIGNED_EN(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .signed_mode(signed_mode), .out_valid(out_valid1), .out_ready(out_ready),
    .out_sum(out_sum1), .out_product(out_product1), .busy(busy1));

  typedef struct {
    logic [W-1:0]   a, b;
    logic           m;
    logic [W:0]     s0;
    logic [2*W-1:0] p0;
    logic [W:0]     s1;
    logic [2*W-1:0] p1;
  } vec_t;

  typedef struct {
    logic [W:0]     s0;
    logic [2*W-1:0] p0;
    logic [W:0]     s1;
    logic [2*W-1:0] p1;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v, input logic s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    exp_t e;
    int su, pu, ss, ps;
    su = sval(a, 1'b0) + sval(b, 1'b0);
    pu = sval(a, 1'b0) * sval(b, 1'b0);
    ss = sval(a, m) + sval(b, m);
    ps = sval(a, m) * sval(b, m);
    e.s0 = su[W:0]; e.p0 = pu[2*W-1:0];
    e.s1 = ss[W:0]; e.p1 = ps[2*W-1:0];
    return e;
  endfunction

  // Accept one pair, track latency/busy, optionally stall in DONE, then handshake.
  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                     input exp_t e, input int hold);
    int cyc, bc;
    exp_t x;
    @(negedge clk);
    chk("in_ready_before_accept", {in_ready0, in_ready1}, 2'b11);
    in_a = a; in_b = b; signed_mode = m; in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; signed_mode = ~m;
    cyc = 1; bc = 0;
    while (!out_valid0 && cyc < 40) begin
      if (busy0 && busy1) bc++;
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, W + 1);
    chk("busy_cycles", bc, W);
    chk("out_valid_pair", {out_valid0, out_valid1}, 2'b11);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      x = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); signed_mode = 1'($urandom);
        @(negedge clk);
        chk("hold_valid_ready", {out_valid0, out_valid1, in_ready0, in_ready1}, 4'b1100);
        chk("hold_sum1", out_sum1, x.s1);
        chk("hold_prod1", out_product1, x.p1);
      end
      in_valid = 1'b0;
      chk("sum_u", out_sum0, x.s0);
      chk("prod_u", out_product0, x.p0);
      chk("sum_s", out_sum1, x.s1);
      chk("prod_s", out_product1, x.p1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_handshake_flags", {out_valid0, out_valid1, in_ready0, in_ready1}, 4'b0011);
      chk("prod_retained", out_product1, x.p1);
    end
  endtask

  vec_t tbl[9];
  exp_t e;

  initial begin
    tbl[0] = '{8'd10,  8'd99,  1'b0, 9'd109, 16'd990,   9'd109,  16'd990};
    tbl[1] = '{8'd255, 8'd255, 1'b0, 9'h1FE, 16'hFE01,  9'h1FE,  16'hFE01};
    tbl[2] = '{8'd0,   8'd200, 1'b0, 9'd200, 16'd0,     9'd200,  16'd0};
    tbl[3] = '{8'hFD,  8'd5,   1'b1, 9'd258, 16'd1265,  9'h002,  16'hFFF1};
    tbl[4] = '{8'd5,   8'hFD,  1'b1, 9'd258, 16'd1265,  9'h002,  16'hFFF1};
    tbl[5] = '{8'h80,  8'h80,  1'b1, 9'h100, 16'h4000,  9'h100,  16'h4000};
    tbl[6] = '{8'h7F,  8'h80,  1'b1, 9'h0FF, 16'h3F80,  9'h1FF,  16'hC080};
    tbl[7] = '{8'h80,  8'h7F,  1'b0, 9'h0FF, 16'h3F80,  9'h0FF,  16'h3F80};
    tbl[8] = '{8'hFF,  8'hFF,  1'b1, 9'h1FE, 16'hFE01,  9'h1FE,  16'h0001};

    repeat (2) @(negedge clk);
    chk("reset_flags", {in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1}, 6'b110000);
    chk("reset_sum", {out_sum0, out_sum1}, '0);
    chk("reset_prod", {out_product0, out_product1}, '0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      txn(tbl[i].a, tbl[i].b, tbl[i].m, '{tbl[i].s0, tbl[i].p0, tbl[i].s1, tbl[i].p1}, 0);

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic rm;
      ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
      txn(ra, rb, rm, model(ra, rb, rm), 0);
    end

    // Backpressure with in_valid asserted and inputs churning, then a clean follow-up.
    txn(8'd200, 8'd3, 1'b0, '{9'd203, 16'd600, 9'd203, 16'd600}, 20);
    txn(8'd33, 8'd132, 1'b0, '{9'd165, 16'd4356, 9'd165, 16'd4356}, 0);

    // Abort in MUL at counter=4: edges 1..4 advance the counter, rst on edge 5.
    @(negedge clk);
    in_a = 8'd10; in_b = 8'd99; signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_abort", {busy0, busy1}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_flags", {in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1}, 6'b110000);
    chk("abort_sum", {out_sum0, out_sum1}, '0);
    chk("abort_prod", {out_product0, out_product1}, '0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (out_valid0 || out_valid1) seen++;
      end
      chk("no_valid_after_abort", seen, 0);
    end
    txn(8'd4, 8'd5, 1'b0, '{9'd9, 16'd20, 9'd9, 16'd20}, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
